// File: rtl/trig_stream_gen_pkg.sv
// Shared types and constants for the trigger-gated ramp stream source.
package trig_stream_pkg;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int SYNC_STAGES    = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;
endpackage

// File: rtl/trig_stream_gen_if.sv
// AXI4-Stream sample bus (no tlast/tkeep) between the ramp source and its consumer.
interface trig_stream_gen_if
    import trig_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/trig_stream_gen_sync.sv
// Brings the asynchronous trigger level into aclk and flags its rising edge.
module trig_sync
    import trig_stream_pkg::*;
(
    input  logic aclk,
    input  logic aresetn,
    input  logic trig,
    output logic edge_pulse
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trig};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Only registered terms, so the pulse carries no path from the trig pin.
    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/trig_stream_gen.sv
// Trigger-gated ramp burst source on AXI4-Stream, plus a free-running divided clock.
//   state  | meaning
//   IDLE   | tvalid low, waiting for a synchronised trigger edge
//   STREAM | tvalid high, ramp advances one step per handshake
module trig_stream_gen
    import trig_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SAMPLES    = 256,
    parameter int CLK_DIV    = 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      trig,
    output logic                      clk_out1,
    output logic                      trig_out,
    trig_stream_gen_if.master         m_axis
);
    localparam logic [DATA_WIDTH-1:0] LAST_VALUE = DATA_WIDTH'(SAMPLES - 1);
    localparam int                    HALF       = CLK_DIV / 2;
    localparam int                    DIV_W      = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0]      DIV_RELOAD = DIV_W'(HALF - 1);

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] next_count;
    logic                  next_trig_out;
    logic                  edge_pulse;
    logic [DIV_W-1:0]      div_cnt;

    trig_sync u_sync (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .trig       (trig),
        .edge_pulse (edge_pulse)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            count    <= '0;
            trig_out <= 1'b0;
        end else begin
            state    <= next_state;
            count    <= next_count;
            trig_out <= next_trig_out;
        end
    end

    // tvalid is high throughout STREAM, so tready alone decides the handshake.
    always_comb begin
        next_state    = state;
        next_count    = count;
        next_trig_out = 1'b0;
        case (state)
            IDLE: begin
                if (edge_pulse) begin
                    next_state    = STREAM;
                    next_count    = '0;
                    next_trig_out = 1'b1;
                end
            end
            STREAM: begin
                if (m_axis.tready) begin
                    if (count == LAST_VALUE) next_state = IDLE;
                    else                     next_count = count + DATA_WIDTH'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        m_axis.tvalid = (state == STREAM);
        m_axis.tdata  = count;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            div_cnt  <= DIV_RELOAD;
            clk_out1 <= 1'b0;
        end else if (div_cnt == '0) begin
            div_cnt  <= DIV_RELOAD;
            clk_out1 <= ~clk_out1;
        end else begin
            div_cnt  <= div_cnt - DIV_W'(1);
        end
    end
endmodule

// File: tb/tb_trig_stream_gen.sv
// Directed scenarios with randomised trigger/ready, checked every cycle against a burst-level model.
module tb_trig_stream_gen;
    import trig_stream_pkg::*;

    localparam int DW = 16;
    localparam int NS = 256;
    localparam int CD = 2;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic trig    = 1'b0;
    logic clk_out1;
    logic trig_out;

    trig_stream_gen_if #(.DATA_WIDTH(DW)) axis ();

    trig_stream_gen #(.DATA_WIDTH(DW), .SAMPLES(NS), .CLK_DIV(CD)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .trig     (trig),
        .clk_out1 (clk_out1),
        .trig_out (trig_out),
        .m_axis   (axis.master)
    );

    always #4 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    // Model: trigger sample history, burst-in-progress flag, current ramp value.
    bit samp[$];
    bit busy;
    int val;
    bit exp_to;
    int since;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        samp = {1'b0, 1'b0, 1'b0, 1'b0};
        busy = 1'b0;
        val = 0;
        exp_to = 1'b0;
        since = 0;
    endtask

    task automatic check_all();
        check("tvalid", {31'd0, axis.tvalid}, {31'd0, busy});
        check("tdata", {16'd0, axis.tdata}, val);
        check("trig_out", {31'd0, trig_out}, {31'd0, exp_to});
        check("clk_out1", {31'd0, clk_out1}, ((since / (CD / 2)) % 2));
    endtask

    // Drive inputs, take one active edge, advance the model, compare after the edge.
    task automatic cycle(bit t, bit r);
        bit rise;
        trig = t;
        axis.tready = r;
        @(posedge aclk);
        if (!aresetn) begin
            model_reset();
        end else begin
            samp.push_front(t);
            if (samp.size() > 8) void'(samp.pop_back());
            rise = samp[2] && !samp[3];
            since++;
            if (busy) begin
                exp_to = 1'b0;
                if (r) begin
                    if (val == NS - 1) busy = 1'b0;
                    else               val++;
                end
            end else if (rise) begin
                busy = 1'b1;
                val = 0;
                exp_to = 1'b1;
            end else begin
                exp_to = 1'b0;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        bit t;
        bit r;
        int guard;
        bit armed;
        axis.tready = 1'b1;
        model_reset();

        // Reset held for 6 cycles, then released and idle until ~580 ns.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
        aresetn = 1'b1;
        for (int i = 0; i < 66; i++) cycle(1'b0, 1'b1);

        // Trigger with tready high: full ramp 0..NS-1.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < NS + 10; i++) cycle(1'b0, 1'b1);

        // Backpressure pattern 1,0,0,1.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < 2 * NS + 20; i++) cycle(1'b0, (i % 4 == 0) || (i % 4 == 3));

        // tready low before the trigger, raised 10 cycles after tvalid.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < NS + 10; i++) cycle(1'b0, 1'b1);

        // Trig held high through a burst with a mid-burst low/high glitch.
        for (int i = 0; i < 60; i++) cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < NS; i++) cycle(1'b1, 1'b1);
        // Re-arm after IDLE.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < NS + 10; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);

        // Edge arriving on the same edge as the final handshake.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        armed = 1'b0;
        for (int i = 0; i < NS + 10; i++) begin
            if (busy && val >= NS - 3) armed = 1'b1;
            cycle(armed, 1'b1);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);

        // Randomised trigger and ready.
        t = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) t = ~t;
            r = ($urandom_range(0, 3) != 0);
            cycle(t, r);
        end
        for (int i = 0; i < 2 * NS; i++) cycle(1'b0, 1'b1);

        // Reset mid-burst at beat 100.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        guard = 0;
        while (!(busy && val == 100) && guard < 400) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        check("beat100_tdata", {16'd0, axis.tdata}, 32'd100);
        #3 aresetn = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        aresetn = 1'b1;
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        for (int i = 0; i < NS + 10; i++) cycle(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
